// File: rtl/muldiv_unit_if.sv
// Operand, control and result bundle between the EX stage and muldiv_unit.
// The master side is the core (or bench); the slave side is the multiply/divide unit.
interface muldiv_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_data, rt_data, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply (shift-add) / restoring divide with HI/LO, fixed 34-cycle latency.
// Define MULDIV_DIV_EN to build the divider; without it DIV/DIVU starts are ignored.
module muldiv_unit (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int DATA_W = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]          r_state;
    logic [5:0]          r_cnt;
    logic                r_busy;
    logic                r_done;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic [1:0]          r_op;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_opnd;
    logic [2*DATA_W-1:0] r_acc;
    logic                r_neg_lo;

    logic                w_accept;
    logic                w_signed;
    logic [DATA_W-1:0]   w_mag_a;
    logic [DATA_W-1:0]   w_mag_b;
    logic [DATA_W:0]     w_add;
    logic [2*DATA_W-1:0] w_acc_next;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_res_hi;
    logic [DATA_W-1:0]   w_res_lo;

    function automatic logic [DATA_W-1:0] f_mag(input logic signed [DATA_W-1:0] v,
                                                input logic is_signed);
        // |0x80000000| wraps back to 0x80000000, which is the correct unsigned magnitude
        f_mag = (is_signed && v[DATA_W-1]) ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [2*DATA_W-1:0] f_cneg64(input logic [2*DATA_W-1:0] v,
                                                     input logic neg);
        f_cneg64 = neg ? (~v + 1'b1) : v;
    endfunction

`ifdef MULDIV_DIV_EN
    logic                r_neg_hi;
    logic [DATA_W:0]     w_rem;
    logic [DATA_W-1:0]   w_diff;

    function automatic logic [DATA_W-1:0] f_cneg32(input logic [DATA_W-1:0] v,
                                                   input logic neg);
        f_cneg32 = neg ? (~v + 1'b1) : v;
    endfunction

    assign w_accept = (r_state == S_IDLE) && bus.start;
`else
    assign w_accept = (r_state == S_IDLE) && bus.start && !bus.op[1];
`endif

    assign w_signed = ~r_op[0];
    assign w_mag_a  = f_mag($signed(r_a), w_signed);
    assign w_mag_b  = f_mag($signed(r_b), w_signed);

    always_comb begin
        w_add      = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + {1'b0, (r_acc[0] ? r_opnd : {DATA_W{1'b0}})};
        w_acc_next = {w_add, r_acc[DATA_W-1:1]};
`ifdef MULDIV_DIV_EN
        w_rem  = r_acc[2*DATA_W-1:DATA_W-1];
        w_diff = w_rem[DATA_W-1:0] - r_opnd;
        if (r_op[1]) begin
            if (w_rem >= {1'b0, r_opnd})
                w_acc_next = {w_diff, r_acc[DATA_W-2:0], 1'b1};
            else
                w_acc_next = {r_acc[2*DATA_W-2:0], 1'b0};
        end
`endif
    end

    always_comb begin
        w_prod   = f_cneg64(r_acc, r_neg_lo);
        w_res_hi = w_prod[2*DATA_W-1:DATA_W];
        w_res_lo = w_prod[DATA_W-1:0];
`ifdef MULDIV_DIV_EN
        if (r_op[1]) begin
            if (r_b == '0) begin
                w_res_hi = r_a;
                w_res_lo = '1;
            end else begin
                w_res_hi = f_cneg32(r_acc[2*DATA_W-1:DATA_W], r_neg_hi);
                w_res_lo = f_cneg32(r_acc[DATA_W-1:0], r_neg_lo);
            end
        end
`endif
    end

    // Datapath: operand latch, magnitude/sign prep, one iteration per CALC cycle
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op <= bus.op;
            r_a  <= bus.rs_data;
            r_b  <= bus.rt_data;
        end
        if (r_state == S_PREP) begin
            r_neg_lo <= w_signed & (r_a[DATA_W-1] ^ r_b[DATA_W-1]);
`ifdef MULDIV_DIV_EN
            r_neg_hi <= w_signed & r_a[DATA_W-1];
`endif
            if (r_op[1]) begin
                r_opnd <= w_mag_b;
                r_acc  <= {{DATA_W{1'b0}}, w_mag_a};
            end else begin
                r_opnd <= w_mag_a;
                r_acc  <= {{DATA_W{1'b0}}, w_mag_b};
            end
        end else if (r_state == S_CALC) begin
            r_acc <= w_acc_next;
        end
    end

    // Control: FSM, counter, HI/LO and handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.hi_we) r_hi <= bus.wdata;
                    if (bus.lo_we) r_lo <= bus.wdata;
                    if (w_accept) begin
                        r_state <= S_PREP;
                        r_busy  <= 1'b1;
                    end
                end
                S_PREP: begin
                    r_cnt   <= '0;
                    r_state <= S_CALC;
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) r_state <= S_FIX;
                end
                default: begin
                    r_hi    <= w_res_hi;
                    r_lo    <= w_res_lo;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus queues expected HI/LO and done cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   tag_ctr = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
        int          tag;
    } exp_t;

    exp_t sb_q[$];

    muldiv_unit_if dif();

    muldiv_unit u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge; E0 is the following posedge, done expected after E0+34.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic exp_done, input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        dif.start   = 1'b1;
        dif.op      = op;
        dif.rs_data = a;
        dif.rt_data = b;
        if (exp_done) begin
            e.hi  = eh;
            e.lo  = el;
            e.due = cyc + 35;
            e.tag = tag_ctr;
            sb_q.push_back(e);
        end
        tag_ctr++;
        @(negedge clk);
        dif.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (dif.done !== 1'b1 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (dif.done !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no done pulse within %0d cycles", name, n);
        end
    endtask

    always @(negedge clk) begin
        if (dif.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, required no pulse", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk($sformatf("op%0d_hi", e.tag), 64'(dif.hi), 64'(e.hi));
                chk($sformatf("op%0d_lo", e.tag), 64'(dif.lo), 64'(e.lo));
                chk($sformatf("op%0d_latency", e.tag), 64'(cyc), 64'(e.due));
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        dif.start = 1'b0; dif.op = 2'b00; dif.rs_data = '0; dif.rt_data = '0;
        dif.hi_we = 1'b0; dif.lo_we = 1'b0; dif.wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_hi",   64'(dif.hi),   64'h0);
        chk("rst_lo",   64'(dif.lo),   64'h0);
        chk("rst_busy", 64'(dif.busy), 64'h0);
        chk("rst_done", 64'(dif.done), 64'h0);

        // MULT 7 x -3, busy window length
        @(negedge clk);
        issue(OP_MULT, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        n = 0;
        while (dif.busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len", 64'(n), 64'd34);
        chk("done_at_busy_fall", 64'(dif.done), 64'h1);

        // MULTU then back-to-back MULT of the same operands
        @(negedge clk);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001);
        wait_done("multu_ff");
        issue(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0001);
        wait_done("mult_ff");
        @(negedge clk);

`ifdef MULDIV_DIV_EN
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        wait_done("div_neg7");
        @(negedge clk);
        issue(OP_DIVU, 32'd100, 32'd0, 1'b1, 32'h0000_0064, 32'hFFFF_FFFF);
        wait_done("divu_zero");
        @(negedge clk);
        issue(OP_DIVU, 32'd10, 32'd3, 1'b1, 32'h0000_0001, 32'h0000_0003);
        wait_done("divu_10_3");
        @(negedge clk);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000);
        wait_done("div_ovf");
        @(negedge clk);
`else
        issue(OP_DIVU, 32'd10, 32'd3, 1'b0, 32'h0, 32'h0);
        chk("nodiv_busy0", 64'(dif.busy), 64'h0);
        repeat (40) @(negedge clk);
        chk("nodiv_busy1", 64'(dif.busy), 64'h0);
        chk("nodiv_hi", 64'(dif.hi), 64'h0);
        chk("nodiv_lo", 64'(dif.lo), 64'h1);
        issue(OP_MULT, 32'd2, 32'd3, 1'b1, 32'h0, 32'h6);
        wait_done("mult_2_3");
        @(negedge clk);
`endif

        // Start and MTHI while busy are ignored; start in done cycle chains
        issue(OP_MULTU, 32'd3, 32'd5, 1'b1, 32'h0, 32'h0000_000F);
        repeat (9) @(negedge clk);
        dif.start = 1'b1; dif.op = OP_MULT; dif.rs_data = 32'd100; dif.rt_data = 32'd100;
        dif.hi_we = 1'b1; dif.wdata = 32'h1234;
        @(negedge clk);
        dif.start = 1'b0; dif.hi_we = 1'b0;
        chk("busy_hi_we_ignored", 64'(dif.hi), 64'h0);
        chk("busy_mid_op", 64'(dif.busy), 64'h1);
        wait_done("multu_3_5");
        issue(OP_MULT, 32'd2, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        wait_done("mult_2_m3");
        @(negedge clk);

        // Reset at E20 aborts with no done pulse
        issue(OP_MULT, 32'd5, 32'd6, 1'b0, 32'h0, 32'h0);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 64'(dif.busy), 64'h0);
        chk("abort_hi",   64'(dif.hi),   64'h0);
        chk("abort_lo",   64'(dif.lo),   64'h0);
        chk("abort_done", 64'(dif.done), 64'h0);
        repeat (40) @(negedge clk);

        // MTLO, then MTHI+MTLO together
        dif.lo_we = 1'b1; dif.wdata = 32'h0000_ABCD;
        @(negedge clk);
        dif.lo_we = 1'b0;
        chk("mtlo_lo", 64'(dif.lo), 64'h0000_ABCD);
        chk("mtlo_hi", 64'(dif.hi), 64'h0);
        dif.hi_we = 1'b1; dif.lo_we = 1'b1; dif.wdata = 32'h5A5A_5A5A;
        @(negedge clk);
        dif.hi_we = 1'b0; dif.lo_we = 1'b0;
        chk("mtboth_hi", 64'(dif.hi), 64'h5A5A_5A5A);
        chk("mtboth_lo", 64'(dif.lo), 64'h5A5A_5A5A);

        // Start with MTHI in IDLE: MT lands now, result overwrites later
        dif.hi_we = 1'b1; dif.wdata = 32'h0000_0077;
        issue(OP_MULTU, 32'd4, 32'd4, 1'b1, 32'h0, 32'h0000_0010);
        dif.hi_we = 1'b0;
        chk("start_mt_hi", 64'(dif.hi), 64'h0000_0077);
        chk("start_mt_lo", 64'(dif.lo), 64'h5A5A_5A5A);
        chk("start_mt_busy", 64'(dif.busy), 64'h1);
        wait_done("multu_4_4");

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It sits in EX, directly downstream of `registers`: it consumes the two register-file read operands (rs, rt) for MULT/MULTU/DIV/DIVU and holds the results for MFHI/MFLO. It also accepts MTHI/MTLO writes and raises `busy` so the hazard logic can stall dependent instructions.

## Interface
- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  launch operation; sampled only in IDLE.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_data`  in  32  operand A (multiplicand / dividend), from `Readdata1`.
- `rt_data`  in  32  operand B (multiplier / divisor), from `Readdata2`.
- `hi_we`  in  1  MTHI: write `wdata` to HI.
- `lo_we`  in  1  MTLO: write `wdata` to LO.
- `wdata`  in  32  MTHI/MTLO data.
- `busy`  out  1  operation in flight; stall MFHI/MFLO/MT*/new mul-div.
- `done`  out  1  one-cycle pulse: HI/LO just updated with the result.
- `hi`  out  32  HI register (registered output).
- `lo`  out  32  LO register (registered output).

## Operation
- FSM states: IDLE, PREP, CALC, FIX.
- IDLE: `start`=1 latches `op`, `rs_data`, `rt_data` -> PREP; `busy`=1 from the next cycle.
- PREP (1 cycle): signed ops take magnitudes (|0x80000000| = 0x80000000 as 32-bit unsigned); record result sign(s); clear 6-bit iteration counter -> CALC.
- CALC (32 cycles): multiply is shift-add into a 64-bit accumulator, one bit per cycle; divide is restoring shift-subtract, one quotient bit per cycle. Counter 0..31; at 31 -> FIX.
- FIX (1 cycle): apply signs, write HI/LO, assert `done` -> IDLE.
- Multiply: {HI,LO} = 64-bit product (signed for MULT, unsigned for MULTU).
- Divide: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
- Divide by zero (DIV or DIVU): HI = `rs_data`, LO = 32'hFFFFFFFF; latency unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- `start`, `hi_we`, `lo_we` are ignored while `busy`=1.
- IDLE, `start` together with `hi_we`/`lo_we`: both the MT write and the launch take effect; the operation result later overwrites HI and LO.
- `hi_we` and `lo_we` together: both registers written with `wdata`.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, counter 0.
- A reset mid-operation aborts; HI/LO are cleared and no `done` pulses.
- `start` sampled at edge E0 -> `busy`=1 after E0 -> FIX at E33 -> after E34, `hi`/`lo` hold the result, `done`=1 for exactly one cycle, `busy`=0.
- Fixed latency is 34 cycles from start edge to `done`, for every op and operand value.
- `start` in the `done` cycle is accepted, giving back-to-back operations.
- MTHI/MTLO: `hi`/`lo` update one cycle after the `hi_we`/`lo_we` edge.
- `busy` is a registered output, low in IDLE and high in PREP/CALC/FIX.

## Configuration
- `MULDIV_DIV_EN` defined: divider datapath is built; DIV/DIVU behave as above.
- Not defined: divider logic is omitted. `start` with `op[1]`=1 is ignored: stays IDLE, `busy`=0, no `done`, HI/LO unchanged. MULT/MULTU and MT* are unaffected.

## Test plan
- Reset, then MULT 7 x 0xFFFFFFFD -> `done` at E34, HI=FFFFFFFF, LO=FFFFFFEB; `busy` high for exactly 34 cycles.
- MULTU FFFFFFFF x FFFFFFFF -> HI=FFFFFFFE, LO=00000001; then MULT of the same operands -> HI=00000000, LO=00000001.
- DIV 0xFFFFFFF9 / 2 -> LO=FFFFFFFD, HI=FFFFFFFF; DIVU 100 / 0 -> HI=00000064, LO=FFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=80000000, HI=0.
- Second `start` and `hi_we`=1 (wdata=1234) at E10 of a MULTU 3 x 5 -> both ignored; HI=0, LO=0000000F; `start` in the `done` cycle begins the next op.
- `reset` at E20 of a MULT -> next cycle: `busy`=0, `hi`=`lo`=0, no `done` ever pulses; MTLO 0xABCD afterwards -> `lo`=0000ABCD one cycle later.
- Build without `MULDIV_DIV_EN`: DIVU 10 / 3 `start` -> `busy` stays 0, no `done`, HI/LO unchanged; MULT 2 x 3 -> LO=6.
